// File: rtl/capture_sequencer.sv
// capture_sequencer
//   Runs one capture for the index compressor: arm, pre-trigger holdoff,
//   trigger search, post-trigger fill, done. It gates the compressor's sample
//   strobe, issues the compressor clear, and latches the compressor index at
//   which the trigger sample was taken.
//
// Ports
//   clk, rst_n               clock; asynchronous active-low reset
//   arm, abort, sw_trig      control pulses
//   trig_mask, trig_value    trigger compare (mask bit 1 = compare that bit)
//   pre_len, post_len        holdoff / post-trigger sample counts, sampled at arm / trigger
//   sample, sample_strobe    raw sample stream (same stream the compressor sees)
//   index                    compressor's current index register
//   scan_strobe              gated strobe to the compressor (combinational)
//   scan_clear               one-cycle compressor clear after an accepted arm
//   trig_index, trig_valid   index at the trigger sample, and its validity
//   busy                     capture in progress (HOLDOFF, WAIT_TRIG, POST)
//   done                     one-cycle pulse on entry to DONE
//   state_dbg                current FSM state, for debug/observation
//
// Handshake: sample_strobe is a valid-only qualifier with no backpressure.
// A sample is consumed in the cycle its strobe is high; scan_strobe is the
// same-cycle forward of that strobe and is never delayed or held.
module capture_sequencer #(
    parameter int INDEX_WIDTH = 60,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   sw_trig,
    input  logic [15:0]            trig_mask,
    input  logic [15:0]            trig_value,
    input  logic [CNT_WIDTH-1:0]   pre_len,
    input  logic [CNT_WIDTH-1:0]   post_len,
    input  logic [15:0]            sample,
    input  logic                   sample_strobe,
    input  logic [INDEX_WIDTH-1:0] index,
    output logic                   scan_strobe,
    output logic                   scan_clear,
    output logic [INDEX_WIDTH-1:0] trig_index,
    output logic                   trig_valid,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HOLDOFF   = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t                 state, state_d;
    logic [CNT_WIDTH-1:0]   cnt, cnt_d;
    logic                   sw_flag, sw_flag_d;
    logic [INDEX_WIDTH-1:0] trig_index_d;
    logic                   trig_valid_d;
    logic                   scan_clear_d;
    logic                   done_d;

    logic active;
    logic accept;
    logic match;
    logic last_cnt;

    assign active = (state == S_HOLDOFF) || (state == S_WAIT_TRIG) || (state == S_POST);
    // The clear cycle must not pass a strobe: the compressor is being reset then.
    // Such a sample is simply dropped and not counted.
    assign accept    = sample_strobe && active && !abort && !scan_clear;
    assign match     = ((sample ^ trig_value) & trig_mask) == 16'h0000;
    // cnt==0 cannot occur in HOLDOFF/POST; treating it as the last sample keeps
    // the FSM from ever stalling there.
    assign last_cnt  = (cnt == CNT_ONE) || (cnt == CNT_ZERO);

    assign scan_strobe = accept;
    assign busy        = active;
    assign state_dbg   = state;

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        sw_flag_d    = sw_flag;
        trig_index_d = trig_index;
        trig_valid_d = trig_valid;
        scan_clear_d = 1'b0;

        if (abort) begin
            // Abort beats arm, sw_trig and any trigger in the same cycle.
            state_d      = S_IDLE;
            trig_valid_d = 1'b0;
            sw_flag_d    = 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        cnt_d        = pre_len;
                        trig_valid_d = 1'b0;
                        sw_flag_d    = 1'b0;
                        scan_clear_d = 1'b1;
                        state_d      = (pre_len != CNT_ZERO) ? S_HOLDOFF : S_WAIT_TRIG;
                    end
                end
                S_HOLDOFF: begin
                    // Holdoff samples are never trigger candidates, including the last one.
                    if (accept) begin
                        if (cnt != CNT_ZERO) cnt_d = cnt - CNT_ONE;
                        if (last_cnt) state_d = S_WAIT_TRIG;
                    end
                end
                S_WAIT_TRIG: begin
                    if (accept && (match || sw_flag || sw_trig)) begin
                        // index still holds the value from before this sample.
                        trig_index_d = index;
                        trig_valid_d = 1'b1;
                        sw_flag_d    = 1'b0;
                        cnt_d        = post_len;
                        state_d      = (post_len != CNT_ZERO) ? S_POST : S_DONE;
                    end else if (sw_trig) begin
                        sw_flag_d = 1'b1;
                    end
                end
                S_POST: begin
                    if (accept) begin
                        if (cnt != CNT_ZERO) cnt_d = cnt - CNT_ONE;
                        if (last_cnt) state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        done_d = (state_d == S_DONE) && (state != S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sw_flag    <= 1'b0;
            trig_index <= '0;
            trig_valid <= 1'b0;
            scan_clear <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sw_flag    <= sw_flag_d;
            trig_index <= trig_index_d;
            trig_valid <= trig_valid_d;
            scan_clear <= scan_clear_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer
//   Directed bench for capture_sequencer. Each record holds one cycle of
//   inputs plus the expected gated strobe (before the edge) and the expected
//   registered outputs (after the edge). A small scoreboard holds the
//   trig_index expected at each rising edge of trig_valid.
module tb_capture_sequencer;

    localparam int IW = 60;
    localparam int CW = 32;

    typedef struct {
        logic          arm;
        logic          abort;
        logic          sw;
        logic          stb;
        logic [15:0]   smp;
        logic [IW-1:0] idx;
        logic [15:0]   mask;
        logic [15:0]   value;
        logic [CW-1:0] pre;
        logic [CW-1:0] post;
        logic          e_strobe;
        logic          e_clear;
        logic          e_busy;
        logic          e_done;
        logic          e_tvalid;
        logic [IW-1:0] e_tidx;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          arm, abort, sw_trig;
    logic [15:0]   trig_mask, trig_value;
    logic [CW-1:0] pre_len, post_len;
    logic [15:0]   sample;
    logic          sample_strobe;
    logic [IW-1:0] index;
    logic          scan_strobe, scan_clear, trig_valid, busy, done;
    logic [IW-1:0] trig_index;
    logic [2:0]    state_dbg;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] exp_q[$];
    logic          tv_prev = 1'b0;

    logic [15:0]   cur_mask;
    logic [15:0]   cur_value;
    logic [CW-1:0] cur_pre;
    logic [CW-1:0] cur_post;

    vec_t tbl[$];

    capture_sequencer #(.INDEX_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .arm           (arm),
        .abort         (abort),
        .sw_trig       (sw_trig),
        .trig_mask     (trig_mask),
        .trig_value    (trig_value),
        .pre_len       (pre_len),
        .post_len      (post_len),
        .sample        (sample),
        .sample_strobe (sample_strobe),
        .index         (index),
        .scan_strobe   (scan_strobe),
        .scan_clear    (scan_clear),
        .trig_index    (trig_index),
        .trig_valid    (trig_valid),
        .busy          (busy),
        .done          (done),
        .state_dbg     (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic void cfg(input logic [15:0] m, input logic [15:0] v,
                                input logic [CW-1:0] pr, input logic [CW-1:0] po);
        cur_mask  = m;
        cur_value = v;
        cur_pre   = pr;
        cur_post  = po;
    endfunction

    function automatic vec_t mk(input logic a, input logic ab, input logic sw, input logic st,
                                input logic [15:0] smp, input logic [IW-1:0] idx,
                                input logic es, input logic ec, input logic eb,
                                input logic ed, input logic ev, input logic [IW-1:0] eti);
        vec_t v;
        v.arm = a;   v.abort = ab;  v.sw = sw;  v.stb = st;
        v.smp = smp; v.idx = idx;
        v.mask = cur_mask; v.value = cur_value; v.pre = cur_pre; v.post = cur_post;
        v.e_strobe = es; v.e_clear = ec; v.e_busy = eb;
        v.e_done = ed;   v.e_tvalid = ev; v.e_tidx = eti;
        return v;
    endfunction

    // driver: drive at negedge, check the combinational strobe before the
    // edge, check registered outputs #1 after the edge
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        arm           = v.arm;
        abort         = v.abort;
        sw_trig       = v.sw;
        sample_strobe = v.stb;
        sample        = v.smp;
        index         = v.idx;
        trig_mask     = v.mask;
        trig_value    = v.value;
        pre_len       = v.pre;
        post_len      = v.post;
        #1;
        chk({tag, ".scan_strobe"}, 64'(scan_strobe), 64'(v.e_strobe));
        @(posedge clk);
        #1;
        chk({tag, ".scan_clear"}, 64'(scan_clear), 64'(v.e_clear));
        chk({tag, ".busy"},       64'(busy),       64'(v.e_busy));
        chk({tag, ".done"},       64'(done),       64'(v.e_done));
        chk({tag, ".trig_valid"}, 64'(trig_valid), 64'(v.e_tvalid));
        chk({tag, ".trig_index"}, 64'(trig_index), 64'(v.e_tidx));
    endtask

    // scoreboard: each rising edge of trig_valid must deliver the next expected index
    always @(negedge clk) begin
        if (rst_n) begin
            if (trig_valid && !tv_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_trigger actual=%h expected=none", trig_index);
                end else begin
                    chk("sb_trig_index", 64'(trig_index), 64'(exp_q.pop_front()));
                end
            end
            tv_prev = trig_valid;
        end
    end

    initial begin
        rst_n = 1'b0;
        arm = 0; abort = 0; sw_trig = 0; sample_strobe = 1'b0;
        sample = '0; index = '0;
        trig_mask = '0; trig_value = '0; pre_len = '0; post_len = '0;

        // ---- table: tests 1..4 ----
        // 1: holdoff 2, post 3, trigger on 0x00AA
        cfg(16'hFFFF, 16'h00AA, 2, 3);
        tbl.push_back(mk(1,0,0,0, 16'h0000,  0, 0,1,1,0,0, 0));
        tbl.push_back(mk(0,0,0,0, 16'h0000,  0, 0,0,1,0,0, 0));
        tbl.push_back(mk(0,0,0,1, 16'h0001, 10, 1,0,1,0,0, 0));
        tbl.push_back(mk(0,0,0,1, 16'h0002, 11, 1,0,1,0,0, 0));
        tbl.push_back(mk(0,0,0,1, 16'h0003, 12, 1,0,1,0,0, 0));
        tbl.push_back(mk(0,0,0,1, 16'h00AA, 13, 1,0,1,0,1, 13));
        tbl.push_back(mk(0,0,0,1, 16'h0005, 14, 1,0,1,0,1, 13));
        tbl.push_back(mk(0,0,0,1, 16'h0006, 15, 1,0,1,0,1, 13));
        tbl.push_back(mk(0,0,0,1, 16'h0007, 16, 1,0,0,1,1, 13));
        tbl.push_back(mk(0,0,0,1, 16'h0008, 17, 0,0,0,0,1, 13));
        tbl.push_back(mk(0,0,0,0, 16'h0000, 17, 0,0,0,0,1, 13));
        // 2: holdoff sample matching the pattern is not a candidate
        cfg(16'hFFFF, 16'h0005, 1, 1);
        tbl.push_back(mk(1,0,0,0, 16'h0000,  0, 0,1,1,0,0, 13));
        tbl.push_back(mk(0,0,0,0, 16'h0000,  0, 0,0,1,0,0, 13));
        tbl.push_back(mk(0,0,0,1, 16'h0005, 20, 1,0,1,0,0, 13));
        tbl.push_back(mk(0,0,0,1, 16'h0005, 21, 1,0,1,0,1, 21));
        tbl.push_back(mk(0,0,0,1, 16'h0009, 22, 1,0,0,1,1, 21));
        tbl.push_back(mk(0,0,0,0, 16'h0000, 22, 0,0,0,0,1, 21));
        // 3: zero lengths, mask 0; strobe in the clear cycle is dropped
        cfg(16'h0000, 16'h0000, 0, 0);
        tbl.push_back(mk(1,0,0,0, 16'h0000,  0, 0,1,1,0,0, 21));
        tbl.push_back(mk(0,0,0,1, 16'h0077, 30, 0,0,1,0,0, 21));
        tbl.push_back(mk(0,0,0,1, 16'h1111, 31, 1,0,0,1,1, 31));
        tbl.push_back(mk(0,0,0,1, 16'h2222, 32, 0,0,0,0,1, 31));
        // 4: sw_trig ignored in HOLDOFF, sticky in WAIT_TRIG
        cfg(16'hFFFF, 16'hFFFF, 1, 1);
        tbl.push_back(mk(1,0,0,0, 16'h0000,  0, 0,1,1,0,0, 31));
        tbl.push_back(mk(0,0,1,0, 16'h0000,  0, 0,0,1,0,0, 31));
        tbl.push_back(mk(0,0,0,1, 16'h0001, 40, 1,0,1,0,0, 31));
        tbl.push_back(mk(0,0,0,1, 16'h0003, 41, 1,0,1,0,0, 31));
        tbl.push_back(mk(0,0,1,0, 16'h0000, 41, 0,0,1,0,0, 31));
        tbl.push_back(mk(0,0,0,1, 16'h1234, 42, 1,0,1,0,1, 42));
        tbl.push_back(mk(0,0,0,1, 16'h0000, 43, 1,0,0,1,1, 42));
        tbl.push_back(mk(0,0,0,0, 16'h0000, 43, 0,0,0,0,1, 42));

        // reset state (checked while reset is still asserted)
        repeat (3) @(posedge clk);
        @(negedge clk);
        sample_strobe = 1'b1;
        #1;
        chk("rst.scan_strobe", 64'(scan_strobe), 64'(0));
        chk("rst.scan_clear",  64'(scan_clear),  64'(0));
        chk("rst.busy",        64'(busy),        64'(0));
        chk("rst.done",        64'(done),        64'(0));
        chk("rst.trig_valid",  64'(trig_valid),  64'(0));
        chk("rst.trig_index",  64'(trig_index),  64'(0));
        sample_strobe = 1'b0;
        rst_n = 1'b1;

        exp_q.push_back(60'd13);
        exp_q.push_back(60'd21);
        exp_q.push_back(60'd31);
        exp_q.push_back(60'd42);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("tbl_v%0d", i));
        end

        // 5: abort mid-POST with a simultaneous strobe
        exp_q.push_back(60'd50);
        cfg(16'hFFFF, 16'h00AA, 0, 3);
        apply(mk(1,0,0,0, 16'h0000,  0, 0,1,1,0,0, 42), "t5_arm");
        apply(mk(0,0,0,0, 16'h0000,  0, 0,0,1,0,0, 42), "t5_clr");
        apply(mk(0,0,0,1, 16'h00AA, 50, 1,0,1,0,1, 50), "t5_trig");
        apply(mk(0,0,0,1, 16'h0001, 51, 1,0,1,0,1, 50), "t5_post");
        apply(mk(0,1,0,1, 16'h0002, 52, 0,0,0,0,0, 50), "t5_abort");
        apply(mk(0,0,0,0, 16'h0000, 52, 0,0,0,0,0, 50), "t5_idle");
        apply(mk(1,1,0,0, 16'h0000, 52, 0,0,0,0,0, 50), "t5_arm_abort");

        // 6: arm ignored while busy; arm in DONE restarts; lengths latched at arm
        exp_q.push_back(60'd61);
        exp_q.push_back(60'd72);
        cfg(16'hFFFF, 16'h00AA, 0, 1);
        apply(mk(1,0,0,0, 16'h0000,  0, 0,1,1,0,0, 50), "t6_arm");
        apply(mk(0,0,0,0, 16'h0000,  0, 0,0,1,0,0, 50), "t6_clr");
        apply(mk(0,0,0,1, 16'h0001, 60, 1,0,1,0,0, 50), "t6_wait");
        apply(mk(1,0,0,0, 16'h0000, 60, 0,0,1,0,0, 50), "t6_arm_wait");
        apply(mk(0,0,0,1, 16'h00AA, 61, 1,0,1,0,1, 61), "t6_trig");
        apply(mk(1,0,0,1, 16'h0002, 62, 1,0,0,1,1, 61), "t6_arm_post");
        cfg(16'hFFFF, 16'h00AA, 2, 1);
        apply(mk(1,0,0,0, 16'h0000,  0, 0,1,1,0,0, 61), "t6_rearm");
        cfg(16'hFFFF, 16'h00AA, 0, 1);
        apply(mk(0,0,0,0, 16'h0000,  0, 0,0,1,0,0, 61), "t6_clr2");
        apply(mk(0,0,0,1, 16'h0001, 70, 1,0,1,0,0, 61), "t6_hold1");
        apply(mk(0,0,0,1, 16'h00AA, 71, 1,0,1,0,0, 61), "t6_hold2");
        apply(mk(0,0,0,1, 16'h00AA, 72, 1,0,1,0,1, 72), "t6_trig2");
        apply(mk(0,0,0,1, 16'h0003, 73, 1,0,0,1,1, 72), "t6_post2");
        apply(mk(0,1,0,0, 16'h0000, 73, 0,0,0,0,0, 72), "t6_abort_done");

        @(negedge clk);
        chk("sb_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
